// File: rtl/ehl_ahb_matrix_port.sv
// -----------------------------------------------------------------------------
// ehl_ahb_matrix_port
//
// AHB-Lite slave-side port of the bus matrix. MNUM master channels share one
// slave port. Provides round-robin or fixed-priority arbitration, burst hold
// (no master switch while the granted master drives SEQ/BUSY), a one-deep
// address hold buffer per master with HREADY stalling, and combinational
// data-phase routing of write data and responses.
//
// Optional feature: define EHL_AHB_MATRIX_LOCK_EN to add im_hmastlock /
// os_hmastlock and locked-sequence grant hold.
//
// Ports:
//   hclk, hreset      clock, asynchronous active-high reset
//   im_*              per-master address/control/write data (channel i at
//                     [i*W +: W])
//   om_hready         per-master HREADY
//   om_hresp          per-master HRESP (2 bits each)
//   om_hrdata         shared read data back to masters
//   os_*              address/control/write data to the slave, os_hsel
//   is_hrdata/hready/hresp  slave read data, HREADYOUT and HRESP
// -----------------------------------------------------------------------------
module ehl_ahb_matrix_port #(
    parameter int unsigned MNUM = 4,
    parameter int unsigned AW   = 32,
    parameter int unsigned DW   = 32,
    parameter int unsigned RR   = 1
) (
    input  logic                 hclk,
    input  logic                 hreset,
    input  logic [MNUM*AW-1:0]   im_haddr,
    input  logic [MNUM*2-1:0]    im_htrans,
    input  logic [MNUM-1:0]      im_hwrite,
    input  logic [MNUM*3-1:0]    im_hsize,
    input  logic [MNUM*3-1:0]    im_hburst,
    input  logic [MNUM*4-1:0]    im_hprot,
    input  logic [MNUM*DW-1:0]   im_hwdata,
`ifdef EHL_AHB_MATRIX_LOCK_EN
    input  logic [MNUM-1:0]      im_hmastlock,
    output logic                 os_hmastlock,
`endif
    output logic [MNUM-1:0]      om_hready,
    output logic [MNUM*2-1:0]    om_hresp,
    output logic [DW-1:0]        om_hrdata,
    output logic [AW-1:0]        os_haddr,
    output logic [1:0]           os_htrans,
    output logic                 os_hwrite,
    output logic [2:0]           os_hsize,
    output logic [2:0]           os_hburst,
    output logic [3:0]           os_hprot,
    output logic [DW-1:0]        os_hwdata,
    output logic                 os_hsel,
    input  logic [DW-1:0]        is_hrdata,
    input  logic                 is_hready,
    input  logic [1:0]           is_hresp
);

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HR_OKAY  = 2'b00,
        HR_ERROR = 2'b01
    } hresp_e;

    // Arbitration and data-phase state
    logic [MNUM-1:0] r_grant;
    logic [MNUM-1:0] r_dphase;
    logic [MNUM-1:0] r_pending;

    // Per-master address hold buffer
    logic [AW-1:0]   r_haddr  [MNUM];
    logic [1:0]      r_htrans [MNUM];
    logic [MNUM-1:0] r_hwrite;
    logic [2:0]      r_hsize  [MNUM];
    logic [2:0]      r_hburst [MNUM];
    logic [3:0]      r_hprot  [MNUM];

    logic [MNUM-1:0] w_active;
    logic [MNUM-1:0] w_hready;
    logic [MNUM-1:0] w_accept;
    logic [MNUM-1:0] w_set;
    logic [MNUM-1:0] w_clr;
    logic [MNUM-1:0] w_cand;
    logic [MNUM-1:0] w_next_grant;
    logic [MNUM-1:0] w_slave_rdy;

    logic [AW-1:0]   w_haddr;
    logic [1:0]      w_htrans;
    logic            w_hwrite;
    logic [2:0]      w_hsize;
    logic [2:0]      w_hburst;
    logic [3:0]      w_hprot;
    logic [1:0]      w_g_live_htrans;
    logic            w_hold;

`ifdef EHL_AHB_MATRIX_LOCK_EN
    logic [MNUM-1:0] r_hmastlock;
    logic            r_lock_prev;
    logic            w_hmastlock;
`endif

    // -------------------------------------------------------------------------
    // Per-master request, ready and hold-buffer control
    // -------------------------------------------------------------------------
    assign w_slave_rdy = {MNUM{is_hready}};

    always_comb begin
        w_active = '0;
        w_hready = '0;
        for (int unsigned i = 0; i < MNUM; i++) begin
            w_active[i] = im_htrans[i*2+1];
            // A data phase in flight reflects the slave; otherwise a held
            // address stalls the master until it has been issued.
            if (r_dphase[i]) begin
                w_hready[i] = is_hready;
            end else begin
                w_hready[i] = ~r_pending[i];
            end
        end
    end

    assign w_accept = w_hready & w_active;
    // Any accepted address that does not go straight to the slave is parked.
    assign w_set    = w_accept & ~(r_grant & w_slave_rdy);
    assign w_clr    = r_grant & w_slave_rdy & r_pending;

    assign om_hready = w_hready;

    // -------------------------------------------------------------------------
    // Address mux: granted master, from hold regs when it has a parked address
    // -------------------------------------------------------------------------
    always_comb begin
        w_haddr         = '0;
        w_htrans        = HT_IDLE;
        w_hwrite        = 1'b0;
        w_hsize         = '0;
        w_hburst        = '0;
        w_hprot         = '0;
        w_g_live_htrans = HT_IDLE;
`ifdef EHL_AHB_MATRIX_LOCK_EN
        w_hmastlock     = 1'b0;
`endif
        for (int unsigned i = 0; i < MNUM; i++) begin
            if (r_grant[i]) begin
                w_g_live_htrans = im_htrans[i*2 +: 2];
                if (r_pending[i]) begin
                    w_haddr  = r_haddr[i];
                    w_htrans = r_htrans[i];
                    w_hwrite = r_hwrite[i];
                    w_hsize  = r_hsize[i];
                    w_hburst = r_hburst[i];
                    w_hprot  = r_hprot[i];
`ifdef EHL_AHB_MATRIX_LOCK_EN
                    w_hmastlock = r_hmastlock[i];
`endif
                end else begin
                    w_haddr  = im_haddr[i*AW +: AW];
                    w_htrans = im_htrans[i*2 +: 2];
                    w_hwrite = im_hwrite[i];
                    w_hsize  = im_hsize[i*3 +: 3];
                    w_hburst = im_hburst[i*3 +: 3];
                    w_hprot  = im_hprot[i*4 +: 4];
`ifdef EHL_AHB_MATRIX_LOCK_EN
                    w_hmastlock = im_hmastlock[i];
`endif
                end
            end
        end
    end

    assign os_haddr  = w_haddr;
    // Slave must see IDLE for as long as reset is asserted, even if the
    // parked master is driving a transfer.
    assign os_htrans = hreset ? HT_IDLE : w_htrans;
    assign os_hwrite = w_hwrite;
    assign os_hsize  = w_hsize;
    assign os_hburst = w_hburst;
    assign os_hprot  = w_hprot;
    assign os_hsel   = |os_htrans;
`ifdef EHL_AHB_MATRIX_LOCK_EN
    assign os_hmastlock = w_hmastlock;
`endif

    // -------------------------------------------------------------------------
    // Data-phase routing (combinational, no added latency)
    // -------------------------------------------------------------------------
    always_comb begin
        os_hwdata = '0;
        om_hresp  = '0;
        for (int unsigned i = 0; i < MNUM; i++) begin
            if (r_dphase[i]) begin
                os_hwdata          = im_hwdata[i*DW +: DW];
                om_hresp[i*2 +: 2] = is_hresp;
            end else begin
                om_hresp[i*2 +: 2] = HR_OKAY;
            end
        end
    end

    assign om_hrdata = hreset ? '0 : is_hrdata;

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    assign w_cand = r_pending | (w_active & w_hready);

    always_comb begin
        w_hold = (w_g_live_htrans == HT_SEQ) || (w_g_live_htrans == HT_BUSY);
`ifdef EHL_AHB_MATRIX_LOCK_EN
        // Locked sequence keeps the grant until lock drops with HTRANS=IDLE.
        w_hold = w_hold || w_hmastlock ||
                 (r_lock_prev && (w_g_live_htrans != HT_IDLE));
`endif
    end

    always_comb begin
        int unsigned v_gidx;
        logic        v_found;
        w_next_grant = r_grant;
        v_gidx       = 0;
        v_found      = 1'b0;
        for (int unsigned i = 0; i < MNUM; i++) begin
            if (r_grant[i]) begin
                v_gidx = i;
            end
        end
        if (!w_hold && (|w_cand)) begin
            if (RR != 0) begin
                // Search starts just after the current owner; the owner itself
                // is visited last so every other requester gets a turn first.
                for (int unsigned k = 1; k <= MNUM; k++) begin
                    for (int unsigned i = 0; i < MNUM; i++) begin
                        if (!v_found && w_cand[i] && (i == ((v_gidx + k) % MNUM))) begin
                            w_next_grant    = '0;
                            w_next_grant[i] = 1'b1;
                            v_found         = 1'b1;
                        end
                    end
                end
            end else begin
                for (int unsigned i = 0; i < MNUM; i++) begin
                    if (!v_found && w_cand[i]) begin
                        w_next_grant    = '0;
                        w_next_grant[i] = 1'b1;
                        v_found         = 1'b1;
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_grant   <= MNUM'(1);
            r_dphase  <= '0;
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_set;
            if (is_hready) begin
                r_grant  <= w_next_grant;
                r_dphase <= r_grant & {MNUM{w_htrans[1]}};
            end
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_hwrite <= '0;
            for (int unsigned i = 0; i < MNUM; i++) begin
                r_haddr[i]  <= '0;
                r_htrans[i] <= HT_IDLE;
                r_hsize[i]  <= '0;
                r_hburst[i] <= '0;
                r_hprot[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < MNUM; i++) begin
                if (w_set[i]) begin
                    r_haddr[i]  <= im_haddr[i*AW +: AW];
                    r_htrans[i] <= im_htrans[i*2 +: 2];
                    r_hwrite[i] <= im_hwrite[i];
                    r_hsize[i]  <= im_hsize[i*3 +: 3];
                    r_hburst[i] <= im_hburst[i*3 +: 3];
                    r_hprot[i]  <= im_hprot[i*4 +: 4];
                end
            end
        end
    end

`ifdef EHL_AHB_MATRIX_LOCK_EN
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_hmastlock <= '0;
            r_lock_prev <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < MNUM; i++) begin
                if (w_set[i]) begin
                    r_hmastlock[i] <= im_hmastlock[i];
                end
            end
            if (is_hready) begin
                r_lock_prev <= w_hmastlock ||
                               (r_lock_prev && (w_g_live_htrans != HT_IDLE));
            end
        end
    end
`endif

endmodule

// File: tb/tb_ehl_ahb_matrix_port.sv
// -----------------------------------------------------------------------------
// tb_ehl_ahb_matrix_port
//
// Directed bench for ehl_ahb_matrix_port with default parameters (4 masters,
// 32-bit address/data, round-robin). Inputs change 1 ns after the rising edge
// and outputs are sampled 3 ns after it; expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_ehl_ahb_matrix_port;

    localparam int unsigned MNUM = 4;
    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;

    logic                 hclk;
    logic                 hreset;
    logic [MNUM*AW-1:0]   im_haddr;
    logic [MNUM*2-1:0]    im_htrans;
    logic [MNUM-1:0]      im_hwrite;
    logic [MNUM*3-1:0]    im_hsize;
    logic [MNUM*3-1:0]    im_hburst;
    logic [MNUM*4-1:0]    im_hprot;
    logic [MNUM*DW-1:0]   im_hwdata;
    logic [MNUM-1:0]      om_hready;
    logic [MNUM*2-1:0]    om_hresp;
    logic [DW-1:0]        om_hrdata;
    logic [AW-1:0]        os_haddr;
    logic [1:0]           os_htrans;
    logic                 os_hwrite;
    logic [2:0]           os_hsize;
    logic [2:0]           os_hburst;
    logic [3:0]           os_hprot;
    logic [DW-1:0]        os_hwdata;
    logic                 os_hsel;
    logic [DW-1:0]        is_hrdata;
    logic                 is_hready;
    logic [1:0]           is_hresp;

    logic [AW-1:0] m_haddr  [MNUM];
    logic [1:0]    m_htrans [MNUM];
    logic          m_hwrite [MNUM];
    logic [2:0]    m_hsize  [MNUM];
    logic [2:0]    m_hburst [MNUM];
    logic [3:0]    m_hprot  [MNUM];
    logic [DW-1:0] m_hwdata [MNUM];

    int n_checks;
    int n_errors;

    ehl_ahb_matrix_port #(
        .MNUM (MNUM),
        .AW   (AW),
        .DW   (DW),
        .RR   (1)
    ) u_dut (
        .hclk      (hclk),
        .hreset    (hreset),
        .im_haddr  (im_haddr),
        .im_htrans (im_htrans),
        .im_hwrite (im_hwrite),
        .im_hsize  (im_hsize),
        .im_hburst (im_hburst),
        .im_hprot  (im_hprot),
        .im_hwdata (im_hwdata),
        .om_hready (om_hready),
        .om_hresp  (om_hresp),
        .om_hrdata (om_hrdata),
        .os_haddr  (os_haddr),
        .os_htrans (os_htrans),
        .os_hwrite (os_hwrite),
        .os_hsize  (os_hsize),
        .os_hburst (os_hburst),
        .os_hprot  (os_hprot),
        .os_hwdata (os_hwdata),
        .os_hsel   (os_hsel),
        .is_hrdata (is_hrdata),
        .is_hready (is_hready),
        .is_hresp  (is_hresp)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    always_comb begin
        im_haddr  = '0;
        im_htrans = '0;
        im_hwrite = '0;
        im_hsize  = '0;
        im_hburst = '0;
        im_hprot  = '0;
        im_hwdata = '0;
        for (int i = 0; i < MNUM; i++) begin
            im_haddr[i*AW +: AW]  = m_haddr[i];
            im_htrans[i*2 +: 2]   = m_htrans[i];
            im_hwrite[i]          = m_hwrite[i];
            im_hsize[i*3 +: 3]    = m_hsize[i];
            im_hburst[i*3 +: 3]   = m_hburst[i];
            im_hprot[i*4 +: 4]    = m_hprot[i];
            im_hwdata[i*DW +: DW] = m_hwdata[i];
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge hclk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_m(input int m, input logic [1:0] tr, input logic [31:0] a,
                         input logic wr, input logic [2:0] sz, input logic [2:0] bu,
                         input logic [3:0] pr);
        m_htrans[m] = tr;
        m_haddr[m]  = a;
        m_hwrite[m] = wr;
        m_hsize[m]  = sz;
        m_hburst[m] = bu;
        m_hprot[m]  = pr;
    endtask

    task automatic idle_m(input int m);
        m_htrans[m] = 2'b00;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        hreset    = 1'b1;
        is_hready = 1'b1;
        is_hresp  = 2'b00;
        is_hrdata = 32'h1234_5678;
        for (int i = 0; i < MNUM; i++) begin
            set_m(i, 2'b00, 32'h0, 1'b0, 3'd0, 3'd0, 4'd0);
            m_hwdata[i] = '0;
        end
        // Parked master drives a transfer during reset: slave must see IDLE.
        set_m(0, 2'b10, 32'h0000_0F00, 1'b1, 3'd2, 3'd0, 4'd0);

        repeat (2) @(posedge hclk);
        #1;
        settle();
        chk("rst_htrans", 64'(os_htrans), 64'h0);
        chk("rst_hsel",   64'(os_hsel),   64'h0);
        chk("rst_hready", 64'(om_hready), 64'hF);
        chk("rst_hresp",  64'(om_hresp),  64'h0);
        chk("rst_hrdata", 64'(om_hrdata), 64'h0);
        idle_m(0);
        hreset = 1'b0;

        // C1: single master 0 NONSEQ write, live path
        next_cycle();
        set_m(0, 2'b10, 32'h0000_0100, 1'b1, 3'd2, 3'd0, 4'd3);
        settle();
        chk("c1_htrans", 64'(os_htrans), 64'h2);
        chk("c1_haddr",  64'(os_haddr),  64'h100);
        chk("c1_hwrite", 64'(os_hwrite), 64'h1);
        chk("c1_hsize",  64'(os_hsize),  64'h2);
        chk("c1_hprot",  64'(os_hprot),  64'h3);
        chk("c1_hsel",   64'(os_hsel),   64'h1);
        chk("c1_hready", 64'(om_hready), 64'hF);

        // C2: write data of master 0
        next_cycle();
        idle_m(0);
        m_hwdata[0] = 32'hA5A5_0001;
        m_hwdata[1] = 32'h1111_1111;
        settle();
        chk("c2_hwdata", 64'(os_hwdata), 64'hA5A5_0001);
        chk("c2_htrans", 64'(os_htrans), 64'h0);
        chk("c2_hready", 64'(om_hready), 64'hF);
        chk("c2_hresp",  64'(om_hresp),  64'h0);

        // C3: masters 1 and 2 request together while master 0 is parked
        next_cycle();
        set_m(1, 2'b10, 32'h0000_0200, 1'b0, 3'd1, 3'd0, 4'd2);
        set_m(2, 2'b10, 32'h0000_0300, 1'b0, 3'd2, 3'd0, 4'd1);
        settle();
        chk("c3_htrans", 64'(os_htrans), 64'h0);
        chk("c3_hready", 64'(om_hready), 64'hF);

        // C4: master 1 issued from hold regs; live inputs now garbage
        next_cycle();
        set_m(1, 2'b00, 32'hBAD0_0001, 1'b1, 3'd0, 3'd0, 4'd0);
        set_m(2, 2'b00, 32'hBAD0_0002, 1'b1, 3'd0, 3'd0, 4'd0);
        settle();
        chk("c4_haddr",  64'(os_haddr),  64'h200);
        chk("c4_htrans", 64'(os_htrans), 64'h2);
        chk("c4_hwrite", 64'(os_hwrite), 64'h0);
        chk("c4_hsize",  64'(os_hsize),  64'h1);
        chk("c4_hready", 64'(om_hready), 64'b1001);

        // C5: master 2 issued from hold regs; master 1 in data phase
        next_cycle();
        is_hrdata = 32'h1111_2222;
        settle();
        chk("c5_haddr",  64'(os_haddr),  64'h300);
        chk("c5_htrans", 64'(os_htrans), 64'h2);
        chk("c5_hready", 64'(om_hready), 64'b1011);
        chk("c5_hrdata", 64'(om_hrdata), 64'h1111_2222);

        // C6: quiet
        next_cycle();
        settle();
        chk("c6_htrans", 64'(os_htrans), 64'h0);
        chk("c6_hready", 64'(om_hready), 64'hF);

        // C7: master 0 starts INCR4 while grant sits on master 2
        next_cycle();
        set_m(0, 2'b10, 32'h0000_0400, 1'b1, 3'd2, 3'd3, 4'd0);
        settle();
        chk("c7_htrans", 64'(os_htrans), 64'h0);

        // C8: beat 0 from hold regs; master 3 requests
        next_cycle();
        set_m(0, 2'b11, 32'h0000_0404, 1'b1, 3'd2, 3'd3, 4'd0);
        set_m(3, 2'b10, 32'h0000_0500, 1'b0, 3'd2, 3'd0, 4'd0);
        settle();
        chk("c8_haddr",  64'(os_haddr),  64'h400);
        chk("c8_htrans", 64'(os_htrans), 64'h2);
        chk("c8_hburst", 64'(os_hburst), 64'h3);
        chk("c8_hready", 64'(om_hready), 64'b1110);

        // C9..C11: SEQ beats keep the grant on master 0
        next_cycle();
        idle_m(3);
        m_hwdata[0] = 32'hD000_0000;
        settle();
        chk("c9_haddr",  64'(os_haddr),  64'h404);
        chk("c9_htrans", 64'(os_htrans), 64'h3);
        chk("c9_hready", 64'(om_hready), 64'b0111);
        chk("c9_hwdata", 64'(os_hwdata), 64'hD000_0000);

        next_cycle();
        set_m(0, 2'b11, 32'h0000_0408, 1'b1, 3'd2, 3'd3, 4'd0);
        m_hwdata[0] = 32'hD000_0001;
        settle();
        chk("c10_haddr",  64'(os_haddr),  64'h408);
        chk("c10_hwdata", 64'(os_hwdata), 64'hD000_0001);

        next_cycle();
        set_m(0, 2'b11, 32'h0000_040C, 1'b1, 3'd2, 3'd3, 4'd0);
        m_hwdata[0] = 32'hD000_0002;
        settle();
        chk("c11_haddr",  64'(os_haddr),  64'h40C);
        chk("c11_htrans", 64'(os_htrans), 64'h3);

        next_cycle();
        idle_m(0);
        m_hwdata[0] = 32'hD000_0003;
        settle();
        chk("c12_htrans", 64'(os_htrans), 64'h0);
        chk("c12_hwdata", 64'(os_hwdata), 64'hD000_0003);
        chk("c12_hready", 64'(om_hready), 64'b0111);

        // C13: master 3 finally issued
        next_cycle();
        settle();
        chk("c13_haddr",  64'(os_haddr),  64'h500);
        chk("c13_htrans", 64'(os_htrans), 64'h2);
        chk("c13_hwrite", 64'(os_hwrite), 64'h0);
        chk("c13_hwdata", 64'(os_hwdata), 64'h0);

        // C14: master 1 read request, captured
        next_cycle();
        set_m(1, 2'b10, 32'h0000_0600, 1'b0, 3'd2, 3'd0, 4'd0);
        settle();
        chk("c14_hready", 64'(om_hready), 64'hF);

        // C15: master 1 issued from hold regs
        next_cycle();
        idle_m(1);
        settle();
        chk("c15_haddr",  64'(os_haddr),  64'h600);
        chk("c15_hready", 64'(om_hready), 64'b1101);

        // C16/C17: slave wait states; master 2 request is parked
        next_cycle();
        is_hready = 1'b0;
        set_m(2, 2'b10, 32'h0000_0700, 1'b1, 3'd2, 3'd0, 4'd0);
        settle();
        chk("c16_hready", 64'(om_hready), 64'b1101);

        next_cycle();
        idle_m(2);
        settle();
        chk("c17_hready", 64'(om_hready), 64'b1001);
        chk("c17_htrans", 64'(os_htrans), 64'h0);

        // C18: read data delivered
        next_cycle();
        is_hready = 1'b1;
        is_hrdata = 32'hDEAD_BEEF;
        settle();
        chk("c18_hready", 64'(om_hready), 64'b1011);
        chk("c18_hrdata", 64'(om_hrdata), 64'hDEAD_BEEF);

        // C19: parked master 2 issued afterward
        next_cycle();
        settle();
        chk("c19_haddr",  64'(os_haddr),  64'h700);
        chk("c19_htrans", 64'(os_htrans), 64'h2);
        chk("c19_hwrite", 64'(os_hwrite), 64'h1);

        // C20/C21: two-cycle ERROR to master 2
        next_cycle();
        m_hwdata[2] = 32'h7777_0000;
        is_hready   = 1'b0;
        is_hresp    = 2'b01;
        settle();
        chk("c20_hresp",  64'(om_hresp),  64'h10);
        chk("c20_hready", 64'(om_hready), 64'b1011);
        chk("c20_hwdata", 64'(os_hwdata), 64'h7777_0000);

        next_cycle();
        is_hready = 1'b1;
        settle();
        chk("c21_hresp",  64'(om_hresp),  64'h10);
        chk("c21_hready", 64'(om_hready), 64'hF);

        // C22: stray slave HRESP with no data phase owner
        next_cycle();
        settle();
        chk("c22_hresp", 64'(om_hresp), 64'h0);
        is_hresp = 2'b00;

        // C23/C24: master 1 pending, then reset mid-transfer
        next_cycle();
        set_m(1, 2'b10, 32'h0000_0800, 1'b0, 3'd2, 3'd0, 4'd0);
        settle();

        next_cycle();
        idle_m(1);
        settle();
        chk("c24_haddr",  64'(os_haddr),  64'h800);
        chk("c24_htrans", 64'(os_htrans), 64'h2);
        chk("c24_hready", 64'(om_hready), 64'b1101);
        #1;
        hreset    = 1'b1;
        is_hrdata = 32'hCAFE_F00D;
        is_hresp  = 2'b01;
        #1;
        chk("rst2_htrans", 64'(os_htrans), 64'h0);
        chk("rst2_hsel",   64'(os_hsel),   64'h0);
        chk("rst2_hready", 64'(om_hready), 64'hF);
        chk("rst2_hresp",  64'(om_hresp),  64'h0);
        chk("rst2_hrdata", 64'(om_hrdata), 64'h0);

        next_cycle();
        hreset   = 1'b0;
        is_hresp = 2'b00;

        // C25: grant back on master 0 with live path
        next_cycle();
        set_m(0, 2'b10, 32'h0000_0900, 1'b0, 3'd2, 3'd0, 4'd0);
        settle();
        chk("c25_haddr",  64'(os_haddr),  64'h900);
        chk("c25_htrans", 64'(os_htrans), 64'h2);
        chk("c25_hready", 64'(om_hready), 64'hF);

        next_cycle();
        idle_m(0);
        repeat (2) next_cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
